// File: rtl/mem_wb_unit.sv
// Memory/writeback stage: drives the data-memory handshake for loads/stores and registers the M/W writeback.
// Optional build macro MEM_WB_MISALIGN_TRAP_EN drops misaligned half/word accesses and pulses misalign_err.
module mem_wb_unit #(
    parameter int unsigned word_width     = 32,
    parameter int unsigned reg_addr_width = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      em_valid,
    input  logic [word_width-1:0]     em_result_data,
    input  logic [reg_addr_width-1:0] em_result_tag,
    input  logic                      em_result_valid,
    input  logic                      em_mem_load,
    input  logic                      em_mem_store,
    input  logic [1:0]                em_mem_size,
    input  logic                      em_mem_unsigned,
    input  logic [word_width-1:0]     em_store_data,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [word_width-1:0]     dmem_addr,
    output logic [word_width-1:0]     dmem_wdata,
    output logic [3:0]                dmem_be,
    input  logic                      dmem_gnt,
    input  logic                      dmem_rvalid,
    input  logic [word_width-1:0]     dmem_rdata,
    output logic [word_width-1:0]     reg_wr_data,
    output logic [reg_addr_width-1:0] reg_wr_data_tag,
    output logic                      reg_wr_data_valid,
    output logic                      mem_stall,
    output logic                      misalign_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Access captured when the request is first issued
    logic [word_width-1:0]     addr_q;
    logic [word_width-1:0]     wdata_q;
    logic [3:0]                be_q;
    logic [1:0]                size_q;
    logic                      uns_q;
    logic                      we_q;
    logic [reg_addr_width-1:0] tag_q;
    logic                      rv_q;
    logic                      cap_en;

    logic [word_width-1:0]     wb_data_q, wb_data_d;
    logic [reg_addr_width-1:0] wb_tag_q, wb_tag_d;
    logic                      wb_valid_q, wb_valid_d;

    logic                      em_is_mem, em_half, em_word, em_misalign;
    logic [word_width-1:0]     em_addr, em_wdata;
    logic [3:0]                em_be;

    logic                      req_c, we_c, retire;
    logic [word_width-1:0]     addr_c, wdata_c;
    logic [3:0]                be_c;

    logic [word_width-1:0]     ld_shift, ld_data;

    always_comb begin
        em_is_mem   = em_mem_load | em_mem_store;
        em_half     = (em_mem_size == 2'd1);
        em_word     = em_mem_size[1];
        em_addr     = em_result_data;
        em_misalign = 1'b0;
`ifdef MEM_WB_MISALIGN_TRAP_EN
        em_misalign = (em_half && em_result_data[0]) ||
                      (em_word && (em_result_data[1:0] != 2'b00));
`else
        if (em_half) em_addr[0]   = 1'b0;
        if (em_word) em_addr[1:0] = 2'b00;
`endif
        if (em_word) begin
            em_be    = 4'b1111;
            em_wdata = em_store_data;
        end else if (em_half) begin
            em_be    = 4'b0011 << em_addr[1:0];
            em_wdata = {(word_width/16){em_store_data[15:0]}};
        end else begin
            em_be    = 4'b0001 << em_addr[1:0];
            em_wdata = {(word_width/8){em_store_data[7:0]}};
        end
    end

    always_comb begin
        ld_shift = dmem_rdata >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'd0:    ld_data = uns_q ? {{(word_width-8){1'b0}}, ld_shift[7:0]}
                                     : {{(word_width-8){ld_shift[7]}}, ld_shift[7:0]};
            2'd1:    ld_data = uns_q ? {{(word_width-16){1'b0}}, ld_shift[15:0]}
                                     : {{(word_width-16){ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        cap_en     = 1'b0;
        req_c      = 1'b0;
        we_c       = 1'b0;
        addr_c     = '0;
        wdata_c    = '0;
        be_c       = '0;
        wb_valid_d = 1'b0;
        wb_data_d  = em_result_data;
        wb_tag_d   = em_result_tag;
        case (state_q)
            IDLE: begin
                if (em_valid) begin
                    if (!em_is_mem) begin
                        retire     = 1'b1;
                        wb_valid_d = em_result_valid && (em_result_tag != '0);
                    end else if (em_misalign) begin
                        retire = 1'b1;
                    end else begin
                        req_c   = 1'b1;
                        we_c    = em_mem_store;
                        addr_c  = {em_addr[word_width-1:2], 2'b00};
                        wdata_c = em_wdata;
                        be_c    = em_be;
                        cap_en  = 1'b1;
                        if (dmem_gnt) begin
                            if (em_mem_store) retire  = 1'b1;
                            else              state_d = RESP;
                        end else begin
                            state_d = REQ;
                        end
                    end
                end
            end
            REQ: begin
                req_c   = 1'b1;
                we_c    = we_q;
                addr_c  = {addr_q[word_width-1:2], 2'b00};
                wdata_c = wdata_q;
                be_c    = be_q;
                if (dmem_gnt) begin
                    if (we_q) begin
                        retire  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    retire     = 1'b1;
                    state_d    = IDLE;
                    wb_valid_d = rv_q && (tag_q != '0);
                    wb_data_d  = ld_data;
                    wb_tag_d   = tag_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            we_q       <= 1'b0;
            tag_q      <= '0;
            rv_q       <= 1'b0;
            wb_data_q  <= '0;
            wb_tag_q   <= '0;
            wb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
            if (wb_valid_d) begin
                wb_data_q <= wb_data_d;
                wb_tag_q  <= wb_tag_d;
            end
            if (cap_en) begin
                addr_q  <= em_addr;
                wdata_q <= em_wdata;
                be_q    <= em_be;
                size_q  <= em_mem_size;
                uns_q   <= em_mem_unsigned;
                we_q    <= em_mem_store;
                tag_q   <= em_result_tag;
                rv_q    <= em_result_valid;
            end
        end
    end

`ifdef MEM_WB_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    assign misalign_d = (state_q == IDLE) && em_valid && em_is_mem && em_misalign;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= misalign_d;
    end
    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

    // Request outputs are combinational from E/M in IDLE, so gate them during reset
    assign dmem_req   = rst_n & req_c;
    assign dmem_we    = rst_n & we_c;
    assign dmem_addr  = rst_n ? addr_c  : '0;
    assign dmem_wdata = rst_n ? wdata_c : '0;
    assign dmem_be    = rst_n ? be_c    : '0;

    assign mem_stall         = em_valid & ~retire;
    assign reg_wr_data       = wb_data_q;
    assign reg_wr_data_tag   = wb_tag_q;
    assign reg_wr_data_valid = wb_valid_q;

endmodule
